// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding (one-hot), bit oversampling and default divider.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned TICKS_PER_BIT    = 16;
  localparam int unsigned DEFAULT_TICK_DIV = 163;

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    START  = 5'b00010,
    DATA   = 5'b00100,
`ifdef UART_TX_PARITY_EN
    PARITY = 5'b01000,
`endif
    STOP   = 5'b10000
  } tx_state_e;

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running baud tick divider: one-cycle tick every TICK_DIV clks, synchronously
// restarted by clr so the first tick of a frame lands exactly TICK_DIV clks after clr.
module baud_tick_gen #(
  parameter int unsigned TICK_DIV = 163
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, SIZE data bits LSB-first, optional even parity, SB_TICK-tick stop.
// Optional parity bit compiled in with `define UART_TX_PARITY_EN.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned SIZE     = 8,
  parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV,
  parameter int unsigned SB_TICK  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_start,
  input  logic [SIZE-1:0] d_in,
  output logic            tx,
  output logic            tx_done,
  output logic            busy
);

  localparam int unsigned BW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int unsigned TW = (SB_TICK > TICKS_PER_BIT) ? $clog2(SB_TICK) : $clog2(TICKS_PER_BIT);
  localparam logic [BW-1:0] LAST_BIT  = BW'(SIZE - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(TICKS_PER_BIT - 1);
  localparam logic [TW-1:0] LAST_STOP = TW'(SB_TICK - 1);

  tx_state_e       state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [SIZE-1:0] sh_q, sh_d;
  logic            tx_d, done_d, busy_d;
  logic            tick, clr;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  baud_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    done_d  = 1'b0;
    clr     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        // tx_done blocks acceptance so a requester holding tx_start until done sends once
        if (tx_start && !tx_done) begin
          sh_d    = d_in;
          tick_d  = '0;
          bit_d   = '0;
          clr     = 1'b1;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^d_in;
`endif
        end
      end
      START: begin
        if (tick) begin
          if (tick_q == LAST_TICK) begin
            tick_d  = '0;
            state_d = DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tick_q == LAST_TICK) begin
            tick_d = '0;
            sh_d   = sh_q >> 1;
            if (bit_q == LAST_BIT) begin
              bit_d = '0;
`ifdef UART_TX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (tick_q == LAST_TICK) begin
            tick_d  = '0;
            state_d = STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (tick_q == LAST_STOP) begin
            tick_d  = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tick_d  = '0;
        bit_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so the registered pins change on the same edge
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE) || done_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx      <= 1'b1;
      tx_done <= 1'b0;
      busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx      <= tx_d;
      tx_done <= done_d;
      busy    <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx at TICK_DIV=2 (32 clks per bit).
// Build with UART_TX_PARITY_EN defined to check the parity frame layout.
module tb_uart_tx;

  localparam int BIT_CLKS = 32;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] d_in = '0;
  logic       tx, tx_done, busy;

  int n_cmp = 0;
  int n_bad = 0;
  int done_pulses = 0;

  uart_tx #(.SIZE(8), .TICK_DIV(2), .SB_TICK(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_start (tx_start),
    .d_in     (d_in),
    .tx       (tx),
    .tx_done  (tx_done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tx_done) done_pulses++;

  // Line bit i of the frame is frame[i]: start, d[0..7], [parity], stop
  typedef struct packed {
    logic [7:0]  d;
    logic [7:0]  d_after;
    logic [9:0]  frame_n;
    logic [10:0] frame_p;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] pick(input logic [9:0] fn, input logic [10:0] fp);
`ifdef UART_TX_PARITY_EN
    return fp;
`else
    return {1'b0, fn};
`endif
  endfunction

  // Caller has tx_start=1 and d_in set; next edge accepts.
  // mode 0: drop tx_start after acceptance; 1: hold until the tx_done cycle; 2: keep holding, load d_next.
  task automatic check_frame(input string tag, input logic [10:0] frame, input int mode,
                             input logic [7:0] d_after, input logic [7:0] d_next);
    logic [31:0] seen;
    int early;
    seen  = '0;
    early = 0;
    step();
    check({tag, ".accept_busy"}, 32'(busy), 32'd1);
    if (mode == 0) tx_start = 1'b0;
    d_in = d_after;
    for (int j = 0; j < NBITS * BIT_CLKS; j++) begin
      seen[j % BIT_CLKS] = tx;
      if (tx_done || !busy) early++;
      if (j % BIT_CLKS == BIT_CLKS - 1)
        check($sformatf("%s.bit%0d", tag, j / BIT_CLKS), seen, {32{frame[j / BIT_CLKS]}});
      step();
    end
    check({tag, ".done_busy_in_frame"}, 32'(early), 32'd0);
    check({tag, ".done_cycle"}, 32'({tx_done, busy, tx}), 32'b111);
    if (mode == 1) tx_start = 1'b0;
    if (mode == 2) d_in = d_next;
    step();
    check({tag, ".after_done"}, 32'({tx_done, busy, tx}), 32'b001);
  endtask

  initial begin
    vec_t vecs[3];
    int   quiet_bad;
    int   p0;

    vecs[0] = '{8'hA5, 8'h5A, 10'b1101001010, 11'b10101001010};
    vecs[1] = '{8'h00, 8'hFF, 10'b1000000000, 11'b10000000000};
    vecs[2] = '{8'h07, 8'h00, 10'b1000001110, 11'b11000001110};

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'({tx_done, busy, tx}), 32'b001);
    reset = 1'b1;
    repeat (4) step();
    check("idle_after_release", 32'({tx_done, busy, tx}), 32'b001);

    foreach (vecs[i]) begin
      d_in     = vecs[i].d;
      tx_start = 1'b1;
      check_frame($sformatf("vec%0d", i), pick(vecs[i].frame_n, vecs[i].frame_p), 0,
                  vecs[i].d_after, 8'h00);
      repeat (3) step();
    end

    // Requester holds tx_start until it sees tx_done: exactly one frame
    d_in     = 8'h5A;
    tx_start = 1'b1;
    check_frame("hold", pick(10'b1010110100, 11'b10010110100), 1, 8'h5A, 8'h00);
    quiet_bad = 0;
    for (int j = 0; j < 40; j++) begin
      if (!tx || busy || tx_done) quiet_bad++;
      step();
    end
    check("hold.no_retransmit", 32'(quiet_bad), 32'd0);

    // Back-to-back with tx_start held: second start bit follows one tx_done-free idle clk
    p0       = done_pulses;
    d_in     = 8'h01;
    tx_start = 1'b1;
    check_frame("b2b0", pick(10'b1000000010, 11'b11000000010), 2, 8'h01, 8'h80);
    check_frame("b2b1", pick(10'b1100000000, 11'b11100000000), 0, 8'h80, 8'h00);
    check("b2b.done_pulses", 32'(done_pulses - p0), 32'd2);
    repeat (3) step();

    // Asynchronous reset in the middle of data bit 3
    d_in     = 8'h00;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    repeat (140) step();
    check("rst.in_data_bit3", 32'({busy, tx}), 32'b10);
    #2;
    reset = 1'b0;
    #1;
    check("rst.async_outputs", 32'({tx_done, busy, tx}), 32'b001);
    repeat (3) step();
    check("rst.held", 32'({tx_done, busy, tx}), 32'b001);
    reset = 1'b1;
    step();
    d_in     = 8'h3C;
    tx_start = 1'b1;
    check_frame("after_rst", pick(10'b1001111000, 11'b10001111000), 0, 8'h3C, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
